// File: rtl/irq_ack_dispatch.sv
// irq_ack_dispatch: acknowledge/dispatch side of a 27-channel priority
// interrupt path (3 buses A/B/C x NCH channels).
//   i_req_{a,b,c}   raw level requests; rising edges set pending bits
//   o_pend_{a,b,c}  pending bits presented to the priority encoder
//   i_grant_*       encoder grant (valid, bus, chan); o_grant_ready in IDLE
//   o_vec_*         vector {2'b00,bus,chan} offered to the CPU, i_vec_ready
//   o_ack_{a,b,c}   one-cycle one-hot acknowledge back to the source
//   o_err_bad_grant sticky illegal-grant flag, cleared by i_err_clr

// Per-bus pending lane: edge capture plus set-wins-over-clear pending bits.
module irq_pend_lane #(
  parameter int NCH = 9
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [NCH-1:0] i_req,
  input  logic [NCH-1:0] i_clr,
  output logic [NCH-1:0] o_pend
);
  logic [NCH-1:0] r_req_q;
  logic [NCH-1:0] r_pend;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_q <= '0;
      r_pend  <= '0;
    end else begin
      r_req_q <= i_req;
      // OR-ing the new edge after the clear keeps a coincident edge alive
      r_pend  <= (r_pend & ~i_clr) | (i_req & ~r_req_q);
    end
  end

  assign o_pend = r_pend;
endmodule

module irq_ack_dispatch #(
  parameter int NCH = 9
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [NCH-1:0] i_req_a,
  input  logic [NCH-1:0] i_req_b,
  input  logic [NCH-1:0] i_req_c,
  output logic [NCH-1:0] o_pend_a,
  output logic [NCH-1:0] o_pend_b,
  output logic [NCH-1:0] o_pend_c,
  input  logic           i_grant_valid,
  input  logic [1:0]     i_grant_bus,
  input  logic [3:0]     i_grant_chan,
  output logic           o_grant_ready,
  output logic           o_vec_valid,
  output logic [7:0]     o_vec_data,
  input  logic           i_vec_ready,
  output logic [NCH-1:0] o_ack_a,
  output logic [NCH-1:0] o_ack_b,
  output logic [NCH-1:0] o_ack_c,
  output logic           o_err_bad_grant,
  input  logic           i_err_clr
);
  localparam int NBUS = 3;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESENT = 2'd1;
  localparam logic [1:0] S_ACK     = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  logic [1:0] r_state;
  logic [1:0] r_bus;
  logic [3:0] r_chan;
  logic       r_err;

  logic [NBUS-1:0][NCH-1:0] w_req;
  logic [NBUS-1:0][NCH-1:0] w_pend;
  logic [NBUS-1:0][NCH-1:0] w_ack;
  logic                     w_hit;
  logic                     w_err_set;

  assign w_req = {i_req_c, i_req_b, i_req_a};

  genvar b, c;
  generate
    for (b = 0; b < NBUS; b++) begin : g_bus
      irq_pend_lane #(.NCH(NCH)) u_lane (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (w_req[b]),
        .i_clr   (w_ack[b]),
        .o_pend  (w_pend[b])
      );
      for (c = 0; c < NCH; c++) begin : g_chan
        assign w_ack[b][c] = (r_state == S_ACK) && (r_bus == 2'(b)) && (r_chan == 4'(c));
      end
    end
  endgenerate

  // Only in-range (bus, chan) pairs can match, so bus 3 or chan >= NCH
  // falls out as a miss together with a cleared pending bit.
  always_comb begin
    w_hit = 1'b0;
    for (int ib = 0; ib < NBUS; ib++)
      for (int ic = 0; ic < NCH; ic++)
        if (i_grant_bus == 2'(ib) && i_grant_chan == 4'(ic))
          w_hit = w_pend[ib][ic];
  end

  assign w_err_set = (r_state == S_IDLE) && i_grant_valid && !w_hit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_bus   <= '0;
      r_chan  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_err_set | (r_err & ~i_err_clr);
      case (r_state)
        S_IDLE: begin
          if (i_grant_valid) begin
            r_bus   <= i_grant_bus;
            r_chan  <= i_grant_chan;
            r_state <= w_hit ? S_PRESENT : S_HOLD;
          end
        end
        S_PRESENT: if (i_vec_ready) r_state <= S_ACK;
        S_ACK:     r_state <= S_HOLD;
        S_HOLD:    r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Gated with reset so every output reads 0 while reset is held.
  assign o_grant_ready   = (r_state == S_IDLE) && i_rst_n;
  assign o_vec_valid     = (r_state == S_PRESENT);
  assign o_vec_data      = (r_state == S_PRESENT) ? {2'b00, r_bus, r_chan} : 8'h00;
  assign o_pend_a        = w_pend[0];
  assign o_pend_b        = w_pend[1];
  assign o_pend_c        = w_pend[2];
  assign o_ack_a         = w_ack[0];
  assign o_ack_b         = w_ack[1];
  assign o_ack_c         = w_ack[2];
  assign o_err_bad_grant = r_err;
endmodule

// File: tb/tb_irq_ack_dispatch.sv
// Bench for irq_ack_dispatch: directed scenarios with a vector/ack scoreboard.
module tb_irq_ack_dispatch;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] req_a, req_b, req_c;
  logic [8:0] pend_a, pend_b, pend_c;
  logic       grant_valid;
  logic [1:0] grant_bus;
  logic [3:0] grant_chan;
  logic       grant_ready;
  logic       vec_valid;
  logic [7:0] vec_data;
  logic       vec_ready;
  logic [8:0] ack_a, ack_b, ack_c;
  logic       err_bad_grant;
  logic       err_clr;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [7:0]  vec;
    logic [26:0] ack;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  irq_ack_dispatch #(.NCH(9)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_c(req_c),
    .o_pend_a(pend_a), .o_pend_b(pend_b), .o_pend_c(pend_c),
    .i_grant_valid(grant_valid), .i_grant_bus(grant_bus), .i_grant_chan(grant_chan),
    .o_grant_ready(grant_ready),
    .o_vec_valid(vec_valid), .o_vec_data(vec_data), .i_vec_ready(vec_ready),
    .o_ack_a(ack_a), .o_ack_b(ack_b), .o_ack_c(ack_c),
    .o_err_bad_grant(err_bad_grant), .i_err_clr(err_clr)
  );

  // Drive a grant and record what the CPU side should see for it.
  task automatic grant(input int b, input int c, input bit expect_ok);
    exp_t e;
    grant_valid = 1'b1;
    grant_bus   = 2'(b);
    grant_chan  = 4'(c);
    if (expect_ok) begin
      e.vec = {2'b00, 2'(b), 4'(c)};
      e.ack = '0;
      e.ack[b*9 + c] = 1'b1;
      sb.push_back(e);
    end
  endtask

  // Scoreboard: every offered vector must match the oldest outstanding grant;
  // every ack retires it and must be exactly its one-hot bit.
  always @(negedge clk) begin
    if (rst_n) begin
      if (vec_valid) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL sb_vec unexpected vector got %h exp none", vec_data);
        else if (vec_data !== sb[0].vec) $display("FAIL sb_vec got %h exp %h", vec_data, sb[0].vec);
        else n_pass++;
      end
      if ({ack_c, ack_b, ack_a} != 27'd0) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL sb_ack unexpected ack got %h exp none", {ack_c, ack_b, ack_a});
        else begin
          exp_t e;
          e = sb.pop_front();
          if ({ack_c, ack_b, ack_a} !== e.ack) $display("FAIL sb_ack got %h exp %h", {ack_c, ack_b, ack_a}, e.ack);
          else n_pass++;
        end
      end
    end
  end

  task automatic test_reset;
    vec_ready = 1'b0;
    @(negedge clk); req_b = 9'h010;
    @(negedge clk);
    n_total++; if (pend_b !== 9'h010) $display("FAIL rst_pre_pend got %h exp %h", pend_b, 9'h010); else n_pass++;
    grant(1, 4, 1'b1);
    @(negedge clk); grant_valid = 1'b0;
    n_total++; if ({vec_valid, vec_data} !== 9'h114) $display("FAIL rst_pre_vec got %h exp %h", {vec_valid, vec_data}, 9'h114); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if ({pend_a, pend_b, pend_c} !== 27'd0) $display("FAIL rst_pend got %h exp 0", {pend_a, pend_b, pend_c}); else n_pass++;
    n_total++; if ({vec_valid, vec_data} !== 9'd0) $display("FAIL rst_vec got %h exp 0", {vec_valid, vec_data}); else n_pass++;
    n_total++; if ({ack_a, ack_b, ack_c, err_bad_grant, grant_ready} !== 29'd0) $display("FAIL rst_ack_err_rdy got %h exp 0", {ack_a, ack_b, ack_c, err_bad_grant, grant_ready}); else n_pass++;
    sb.delete();
    req_b = 9'h000;
    @(negedge clk); @(negedge clk); rst_n = 1'b1; vec_ready = 1'b1;
    @(negedge clk);
    n_total++; if ({grant_ready, vec_valid, pend_b} !== {2'b10, 9'h000}) $display("FAIL rst_release got %h exp %h", {grant_ready, vec_valid, pend_b}, {2'b10, 9'h000}); else n_pass++;
  endtask

  task automatic test_single;
    vec_ready = 1'b1;
    @(negedge clk); req_a = 9'h008;
    @(negedge clk);
    n_total++; if (pend_a !== 9'h008) $display("FAIL single_pend got %h exp %h", pend_a, 9'h008); else n_pass++;
    req_a = 9'h000;
    grant(0, 3, 1'b1);
    @(negedge clk); grant_valid = 1'b0;
    n_total++; if ({vec_valid, vec_data, grant_ready} !== {1'b1, 8'h03, 1'b0}) $display("FAIL single_vec got %h exp %h", {vec_valid, vec_data, grant_ready}, {1'b1, 8'h03, 1'b0}); else n_pass++;
    @(negedge clk);
    n_total++; if ({vec_valid, ack_a} !== {1'b0, 9'h008}) $display("FAIL single_ack got %h exp %h", {vec_valid, ack_a}, {1'b0, 9'h008}); else n_pass++;
    @(negedge clk);
    n_total++; if ({pend_a, ack_a, grant_ready} !== 19'd0) $display("FAIL single_hold got %h exp 0", {pend_a, ack_a, grant_ready}); else n_pass++;
    @(negedge clk);
    n_total++; if (grant_ready !== 1'b1) $display("FAIL single_ready got %b exp 1", grant_ready); else n_pass++;
  endtask

  task automatic test_stall;
    @(negedge clk); req_c = 9'h100;
    @(negedge clk); req_c = 9'h000;
    vec_ready = 1'b0;
    grant(2, 8, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); grant_valid = 1'b0;
      n_total++; if ({vec_valid, vec_data} !== {1'b1, 8'h28}) $display("FAIL stall_vec%0d got %h exp %h", i, {vec_valid, vec_data}, {1'b1, 8'h28}); else n_pass++;
    end
    vec_ready = 1'b1;
    @(negedge clk);
    n_total++; if ({ack_c, ack_b, ack_a} !== {9'h100, 18'd0}) $display("FAIL stall_ack got %h exp %h", {ack_c, ack_b, ack_a}, {9'h100, 18'd0}); else n_pass++;
    @(negedge clk);
    n_total++; if (pend_c !== 9'h000) $display("FAIL stall_pend got %h exp 0", pend_c); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_collision;
    vec_ready = 1'b1;
    @(negedge clk); req_b = 9'h001;
    @(negedge clk);
    grant(1, 0, 1'b1);
    @(negedge clk); grant_valid = 1'b0;
    req_b = 9'h000;                     // low while PRESENT
    @(negedge clk);
    n_total++; if (ack_b !== 9'h001) $display("FAIL coll_ack got %h exp %h", ack_b, 9'h001); else n_pass++;
    req_b = 9'h001;                     // rises in the ACK cycle
    @(negedge clk);
    n_total++; if (pend_b !== 9'h001) $display("FAIL coll_pend got %h exp %h", pend_b, 9'h001); else n_pass++;
    @(negedge clk);
    req_b = 9'h000;
    grant(1, 0, 1'b1);                  // consume the re-set bit
    @(negedge clk); grant_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    n_total++; if (pend_b !== 9'h000) $display("FAIL coll_drain got %h exp 0", pend_b); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_illegal;
    int bl[3] = '{3, 0, 1};
    int cl[3] = '{0, 10, 2};
    for (int i = 0; i < 3; i++) begin
      grant(bl[i], cl[i], 1'b0);
      @(negedge clk); grant_valid = 1'b0;
      n_total++; if ({err_bad_grant, vec_valid, grant_ready} !== 3'b100) $display("FAIL illegal%0d_set got %b exp 100", i, {err_bad_grant, vec_valid, grant_ready}); else n_pass++;
      @(negedge clk);
      n_total++; if (grant_ready !== 1'b1) $display("FAIL illegal%0d_ready got %b exp 1", i, grant_ready); else n_pass++;
      err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      n_total++; if (err_bad_grant !== 1'b0) $display("FAIL illegal%0d_clr got %b exp 0", i, err_bad_grant); else n_pass++;
    end
    // set and clear together: set wins
    grant(3, 0, 1'b0);
    @(negedge clk); grant_valid = 1'b0;
    @(negedge clk);
    grant(0, 9, 1'b0); err_clr = 1'b1;
    @(negedge clk); grant_valid = 1'b0; err_clr = 1'b0;
    n_total++; if (err_bad_grant !== 1'b1) $display("FAIL illegal_setwins got %b exp 1", err_bad_grant); else n_pass++;
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  task automatic test_back_to_back;
    int cyc = 0;
    vec_ready = 1'b1;
    @(negedge clk); req_c = 9'h002; req_a = 9'h001;
    @(negedge clk); cyc++; req_a = 9'h000;
    n_total++; if ({pend_a, pend_c} !== {9'h001, 9'h002}) $display("FAIL b2b_pend got %h exp %h", {pend_a, pend_c}, {9'h001, 9'h002}); else n_pass++;
    grant(0, 0, 1'b1);
    @(negedge clk); cyc++; grant_valid = 1'b0;
    n_total++; if ({vec_valid, vec_data} !== {1'b1, 8'h00}) $display("FAIL b2b_vec0 got %h exp %h", {vec_valid, vec_data}, {1'b1, 8'h00}); else n_pass++;
    @(negedge clk); cyc++;
    @(negedge clk); cyc++;
    @(negedge clk); cyc++;
    n_total++; if (grant_ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", grant_ready); else n_pass++;
    grant(2, 1, 1'b1);                  // 4 cycles after the first grant
    @(negedge clk); cyc++; grant_valid = 1'b0;
    n_total++; if ({vec_valid, vec_data} !== {1'b1, 8'h21}) $display("FAIL b2b_vec1 got %h exp %h", {vec_valid, vec_data}, {1'b1, 8'h21}); else n_pass++;
    @(negedge clk); cyc++;
    n_total++; if (ack_c !== 9'h002) $display("FAIL b2b_ack1 got %h exp %h", ack_c, 9'h002); else n_pass++;
    while (cyc < 20) begin
      @(negedge clk); cyc++;
      n_total++; if (pend_c !== 9'h000) $display("FAIL b2b_level cyc%0d got %h exp 0", cyc, pend_c); else n_pass++;
    end
    req_c = 9'h000;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_a = '0; req_b = '0; req_c = '0;
    grant_valid = 1'b0; grant_bus = '0; grant_chan = '0;
    vec_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if ({grant_ready, vec_valid, err_bad_grant, pend_a, pend_b, pend_c} !== 30'd0) $display("FAIL init_reset got %h exp 0", {grant_ready, vec_valid, err_bad_grant, pend_a, pend_b, pend_c}); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (grant_ready !== 1'b1) $display("FAIL init_ready got %b exp 1", grant_ready); else n_pass++;
    test_reset();
    test_single();
    test_stall();
    test_collision();
    test_illegal();
    test_back_to_back();
    repeat (2) @(negedge clk);
    n_total++; if (sb.size() != 0) $display("FAIL sb_leftover got %0d exp 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
